// File: rtl/alu_seq.sv
// alu_seq -- registered ALU for the SAP CPU datapath.
//
// Add/sub with carry, logic, shift, compare and a multi-cycle shift-add
// multiply. Result and {C,Z,N,V} flags are held in registers for the
// controller's jump logic. One op is issued per start pulse. start is
// ignored while a multiply is in progress.
//
// Ports
//   clk_i      rising-edge clock
//   rst_i      asynchronous active-high reset
//   start_i    issue op (sampled only when busy_o=0)
//   op_i       operation code
//   a_i, b_i   operands (accumulator, B register)
//   out_en_i   drive bus_out_o with the result (else 0)
//   result_o   registered result
//   bus_out_o  out_en_i ? result_o : 0 (combinational)
//   flags_o    registered {C,Z,N,V}
//   busy_o     multiply in progress
//   done_o     one-cycle pulse: result/flags valid
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             out_en_i,
  output logic [WIDTH-1:0] result_o,
  output logic [WIDTH-1:0] bus_out_o,
  output logic [3:0]       flags_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  localparam logic [3:0] OP_ADD = 4'h0, OP_SUB = 4'h1, OP_ADC = 4'h2, OP_SBB = 4'h3;
  localparam logic [3:0] OP_AND = 4'h4, OP_OR  = 4'h5, OP_XOR = 4'h6, OP_NOT = 4'h7;
  localparam logic [3:0] OP_SHL = 4'h8, OP_SHR = 4'h9, OP_CMP = 4'hA, OP_MUL = 4'hB;
  localparam logic [3:0] OP_INC = 4'hC, OP_DEC = 4'hD;

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [3:0]         flags_q, flags_d;
  logic               done_q, done_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  // Shared adder: every arithmetic op is a + y + ci with a per-op y/ci.
  logic [WIDTH-1:0] add_y;
  logic             add_ci;
  logic [WIDTH:0]   add_sum;
  logic             add_v;
  logic [2*WIDTH-1:0] prod_next;

  function automatic logic [3:0] mk_flags(input logic [WIDTH-1:0] r,
                                          input logic c, input logic v);
    return {c, (r == '0), r[WIDTH-1], v};
  endfunction

  always_comb begin
    add_y  = b_i;
    add_ci = 1'b0;
    case (op_i)
      OP_SUB, OP_CMP: begin add_y = ~b_i;          add_ci = 1'b1;       end
      OP_ADC:         begin add_y = b_i;           add_ci = flags_q[3]; end
      OP_SBB:         begin add_y = ~b_i;          add_ci = flags_q[3]; end
      OP_INC:         begin add_y = WIDTH'(1);     add_ci = 1'b0;       end
      OP_DEC:         begin add_y = ~WIDTH'(1);    add_ci = 1'b1;       end
      default:        ;
    endcase
  end

  assign add_sum = {1'b0, a_i} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_ci};
  // Signed overflow: both addends share a sign that the sum does not.
  assign add_v   = (a_i[WIDTH-1] == add_y[WIDTH-1]) && (add_sum[WIDTH-1] != a_i[WIDTH-1]);

  // One shift-add step: add the shifted multiplicand when the current
  // multiplier LSB is set.
  assign prod_next = mplier_q[0] ? (prod_q + mcand_q) : prod_q;

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    flags_d  = flags_q;
    done_d   = 1'b0;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          done_d = (op_i != OP_MUL);
          case (op_i)
            OP_ADD, OP_SUB, OP_ADC, OP_SBB, OP_INC, OP_DEC: begin
              result_d = add_sum[WIDTH-1:0];
              flags_d  = mk_flags(add_sum[WIDTH-1:0], add_sum[WIDTH], add_v);
            end
            OP_CMP: flags_d = mk_flags(add_sum[WIDTH-1:0], add_sum[WIDTH], add_v);
            OP_AND: begin result_d = a_i & b_i; flags_d = mk_flags(a_i & b_i, 1'b0, 1'b0); end
            OP_OR:  begin result_d = a_i | b_i; flags_d = mk_flags(a_i | b_i, 1'b0, 1'b0); end
            OP_XOR: begin result_d = a_i ^ b_i; flags_d = mk_flags(a_i ^ b_i, 1'b0, 1'b0); end
            OP_NOT: begin result_d = ~a_i;      flags_d = mk_flags(~a_i, 1'b0, 1'b0);      end
            OP_SHL: begin
              result_d = {a_i[WIDTH-2:0], 1'b0};
              flags_d  = mk_flags({a_i[WIDTH-2:0], 1'b0}, a_i[WIDTH-1], 1'b0);
            end
            OP_SHR: begin
              result_d = {1'b0, a_i[WIDTH-1:1]};
              flags_d  = mk_flags({1'b0, a_i[WIDTH-1:1]}, a_i[0], 1'b0);
            end
            OP_MUL: begin
              state_d  = S_MUL;
              mcand_d  = {{WIDTH{1'b0}}, a_i};
              mplier_d = b_i;
              prod_d   = '0;
              cnt_d    = '0;
            end
            default: ;  // E/F: no state change, done still pulses
          endcase
        end
      end
      S_MUL: begin
        prod_d   = prod_next;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST_ITER) begin
          state_d  = S_IDLE;
          done_d   = 1'b1;
          result_d = prod_next[WIDTH-1:0];
          flags_d  = mk_flags(prod_next[WIDTH-1:0], |prod_next[2*WIDTH-1:WIDTH], 1'b0);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      flags_q  <= '0;
      done_q   <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      done_q   <= done_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
    end
  end

  assign result_o  = result_q;
  assign flags_o   = flags_q;
  assign done_o    = done_q;
  assign busy_o    = (state_q == S_MUL);
  assign bus_out_o = out_en_i ? result_q : '0;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq -- directed bench for alu_seq (WIDTH=8) with an expected-result
// queue filled at issue time and drained whenever done_o pulses.
module tb_alu_seq;

  typedef struct packed {
    logic [3:0] op;
    logic [7:0] res;
    logic [3:0] flags;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       out_en = 1'b0;
  logic [3:0] op_r = 4'h0;
  logic [7:0] a_r = 8'h00;
  logic [7:0] b_r = 8'h00;
  logic [7:0] result, bus_out;
  logic [3:0] flags;
  logic       busy, done;

  int   total = 0;
  int   bad = 0;
  exp_t exp_q[$];
  logic [7:0] m_res = 8'h00;
  logic [3:0] m_flags = 4'h0;

  alu_seq #(.WIDTH(8)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .op_i(op_r), .a_i(a_r), .b_i(b_r),
    .out_en_i(out_en), .result_o(result), .bus_out_o(bus_out), .flags_o(flags),
    .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    total++;
    assert (got === expv) else begin
      bad++;
      $error("FAIL %s: got=%0h expected=%0h", tag, got, expv);
    end
  endtask

  // Reference behaviour computed with plain integer arithmetic.
  task automatic push_exp(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    int ua, ub, sa, sb, c, full, sv, r;
    bit arith, keep, cf;
    exp_t e;
    ua = a; ub = b; c = m_flags[3];
    sa = (ua >= 128) ? ua - 256 : ua;
    sb = (ub >= 128) ? ub - 256 : ub;
    arith = 1; keep = 0; full = 0; sv = 0; r = 0; cf = 0;
    case (op)
      4'h0: begin full = ua + ub;             sv = sa + sb;         end
      4'h1: begin full = ua + (255 - ub) + 1; sv = sa - sb;         end
      4'h2: begin full = ua + ub + c;         sv = sa + sb + c;     end
      4'h3: begin full = ua + (255 - ub) + c; sv = sa - sb - 1 + c; end
      4'hA: begin full = ua + (255 - ub) + 1; sv = sa - sb; keep = 1; end
      4'hC: begin full = ua + 1;              sv = sa + 1;          end
      4'hD: begin full = ua + 255;            sv = sa - 1;          end
      default: arith = 0;
    endcase
    if (arith) begin
      r = full % 256;
      m_flags = {full > 255, r == 0, r >= 128, (sv < -128) || (sv > 127)};
      if (!keep) m_res = 8'(r);
    end else if (op != 4'hE && op != 4'hF) begin
      case (op)
        4'h4: r = ua & ub;
        4'h5: r = ua | ub;
        4'h6: r = ua ^ ub;
        4'h7: r = 255 - ua;
        4'h8: begin r = (ua * 2) % 256; cf = (ua >= 128); end
        4'h9: begin r = ua / 2;         cf = (ua % 2) == 1; end
        default: begin r = (ua * ub) % 256; cf = (ua * ub) > 255; end
      endcase
      m_res = 8'(r);
      m_flags = {cf, r == 0, r >= 128, 1'b0};
    end
    e.op = op; e.res = m_res; e.flags = m_flags;
    exp_q.push_back(e);
  endtask

  // Called at a negedge; returns at the negedge after the sampling edge.
  task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    start = 1'b1; op_r = op; a_r = a; b_r = b;
    push_exp(op, a, b);
    @(negedge clk);
    start = 1'b0;
  endtask

  always @(negedge clk) begin
    if (done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'(done), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        $display("txn op=%h result=%0d flags=%b (exp %0d %b)", e.op, result, flags, e.res, e.flags);
        chk("result", 32'(result), 32'(e.res));
        chk("flags", 32'(flags), 32'(e.flags));
      end
    end
  end

  initial begin
    int n;
    repeat (2) @(negedge clk);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_flags", 32'(flags), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // ADD: done one cycle after the start edge, for one cycle only
    issue(4'h0, 8'd45, 8'd10);
    chk("add_done", 32'(done), 32'd1);
    chk("add_result_lit", 32'(result), 32'd55);
    chk("bus_off", 32'(bus_out), 32'd0);
    out_en = 1'b1; #1;
    chk("bus_on", 32'(bus_out), 32'd55);
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'd0);
    out_en = 1'b0;

    // back-to-back subtract / compare
    issue(4'h1, 8'd10, 8'd20);
    issue(4'h1, 8'd31, 8'd11);
    issue(4'hA, 8'd5, 8'd5);
    chk("cmp_keeps_result", 32'(result), 32'd20);
    issue(4'h0, 8'd200, 8'd100);
    issue(4'h2, 8'd1, 8'd1);
    issue(4'h0, 8'd100, 8'd100);
    issue(4'h3, 8'd50, 8'd20);
    issue(4'h4, 8'hF0, 8'h3C);
    issue(4'h5, 8'h00, 8'h00);
    issue(4'h6, 8'hAA, 8'h55);
    issue(4'h7, 8'h0F, 8'h00);
    issue(4'hC, 8'hFF, 8'h00);
    issue(4'hC, 8'h7F, 8'h00);
    issue(4'hD, 8'h00, 8'h00);
    issue(4'hD, 8'h80, 8'h00);
    @(negedge clk);

    // MUL 13*11: busy for 8 cycles; a start mid-busy must be ignored
    issue(4'hB, 8'd13, 8'd11);
    n = 0;
    while (busy && n < 20) begin
      n++;
      a_r = 8'($urandom); b_r = 8'($urandom);
      if (n == 2) begin start = 1'b1; op_r = 4'h0; end
      else start = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    chk("mul_busy_cycles", 32'(n), 32'd8);
    chk("mul_done", 32'(done), 32'd1);
    chk("mul_result_lit", 32'(result), 32'd143);
    @(negedge clk);
    chk("mul_done_one_cycle", 32'(done), 32'd0);

    issue(4'hB, 8'd20, 8'd20);
    n = 0;
    while (busy && n < 20) begin n++; @(negedge clk); end
    chk("mul2_busy_cycles", 32'(n), 32'd8);
    @(negedge clk);

    issue(4'h8, 8'h81, 8'h00);
    issue(4'h9, 8'h01, 8'h00);
    issue(4'hE, 8'h12, 8'h34);
    issue(4'hF, 8'h56, 8'h78);
    chk("nop_result", 32'(result), 32'd0);
    chk("nop_flags", 32'(flags), 32'b1100);
    issue(4'h0, 8'd3, 8'd4);
    @(negedge clk);

    // reset three cycles into a MUL: abandoned, no done pulse
    start = 1'b1; op_r = 4'hB; a_r = 8'd13; b_r = 8'd11;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1; #1;
    chk("mrst_result", 32'(result), 32'd0);
    chk("mrst_flags", 32'(flags), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    m_res = 8'h00; m_flags = 4'h0;
    repeat (12) @(negedge clk);
    chk("post_rst_result", 32'(result), 32'd0);
    issue(4'hC, 8'd9, 8'd0);
    @(negedge clk);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
